// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and status signals of the instruction-memory loader.
// The master drives the stream and start; the slave is the loader.
interface imem_loader_if #(
    parameter int unsigned WordSize  = 16,
    parameter int unsigned AddrWidth = 8
);
    logic                 start;
    logic                 in_valid;
    logic [7:0]           in_data;
    logic                 in_ready;
    logic                 mem_we;
    logic [AddrWidth-1:0] mem_addr;
    logic [WordSize-1:0]  mem_wdata;
    logic                 cpu_hold;
    logic                 done;
    logic                 error;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error
    );
endinterface

// File: rtl/imem_loader.sv
// Loads instruction memory from a byte stream: a 16-bit big-endian word count,
// then each word MSB-first, with the CPU held until the load finishes.
module imem_loader #(
    parameter int unsigned WordSize  = 16,
    parameter int unsigned AddrWidth = 8
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.slave  bus
);
    localparam int unsigned BytesPerWord = WordSize / 8;
    localparam int unsigned CntWidth     = $clog2(BytesPerWord + 1);
    localparam int unsigned LenWidth     = 16;

    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, BYTE, WRITE, DONE} state_t;

    state_t               state;
    state_t               state_next;
    logic [7:0]           len_hi;
    logic [LenWidth-1:0]  remaining;
    logic [CntWidth-1:0]  byte_cnt;
    logic [WordSize-1:0]  word;
    logic [AddrWidth-1:0] addr;
    logic                 in_ready;
    logic                 mem_we;
    logic                 cpu_hold;
    logic                 done;
    logic                 error;

    logic                 accept;
    logic [LenWidth-1:0]  len_full;
    logic                 len_bad;
    logic                 word_end;

    // Length of zero, or one larger than memory, aborts the load without writes.
    assign accept   = bus.in_valid && in_ready;
    assign len_full = {len_hi, bus.in_data};
    assign len_bad  = (len_full == '0) || (32'(len_full) > (32'd1 << AddrWidth));
    assign word_end = (byte_cnt == CntWidth'(BytesPerWord - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = LEN_HI;
            LEN_HI:  if (accept) state_next = LEN_LO;
            LEN_LO:  if (accept) state_next = len_bad ? DONE : BYTE;
            BYTE:    if (accept && word_end) state_next = WRITE;
            WRITE:   state_next = (remaining == LenWidth'(1)) ? DONE : BYTE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered outputs, decoded from the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_hi    <= '0;
            remaining <= '0;
            byte_cnt  <= '0;
            word      <= '0;
            addr      <= '0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            cpu_hold  <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    addr  <= '0;
                    error <= 1'b0;
                end
                LEN_HI: if (accept) len_hi <= bus.in_data;
                LEN_LO: if (accept) begin
                    remaining <= len_full;
                    byte_cnt  <= '0;
                    if (len_bad) error <= 1'b1;
                end
                BYTE: if (accept) begin
                    word     <= WordSize'({word, bus.in_data});
                    byte_cnt <= byte_cnt + CntWidth'(1);
                end
                WRITE: begin
                    addr      <= addr + AddrWidth'(1);
                    remaining <= remaining - LenWidth'(1);
                    byte_cnt  <= '0;
                end
                default: ;
            endcase
            in_ready <= (state_next == LEN_HI) || (state_next == LEN_LO) || (state_next == BYTE);
            mem_we   <= (state_next == WRITE);
            cpu_hold <= (state_next != IDLE);
            done     <= (state_next == DONE);
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = word;
    assign bus.cpu_hold  = cpu_hold;
    assign bus.done      = done;
    assign bus.error     = error;
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes and done/error outcomes are queued
// by the stimulus and checked by a monitor whenever mem_we or done is seen.
module tb_imem_loader;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    imem_loader_if #(.WordSize(16), .AddrWidth(8)) bus();
    imem_loader #(.WordSize(16), .AddrWidth(8)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t  exp_w[$];
    bit   exp_d[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   we_prev = 0;
    int   we_last = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes or finishes.
    always @(negedge clk) begin
        if (!reset && bus.mem_we) begin
            we_prev = we_last;
            we_last = cyc;
            if (exp_w.size() == 0) check("unexpected_write", {8'h0, bus.mem_addr, bus.mem_wdata}, 32'h0);
            else begin
                wr_t e;
                e = exp_w.pop_front();
                check("write_addr", 32'(bus.mem_addr), 32'(e.addr));
                check("write_data", 32'(bus.mem_wdata), 32'(e.data));
            end
        end
        if (!reset && bus.done) begin
            if (exp_d.size() == 0) check("unexpected_done", 32'(bus.done), 32'h0);
            else check("done_error", 32'(bus.error), 32'(exp_d.pop_front()));
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    // Present one byte and return just after the edge that accepts it.
    task automatic send_byte(input logic [7:0] b);
        bit got;
        got = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                step();
                got = 1'b1;
            end
        end
        if (!got) check("accept_timeout", 32'h0, 32'h1);
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                check({name, "_hold_at_done"}, 32'(bus.cpu_hold), 32'h1);
                @(negedge clk);
                check({name, "_done_one_cycle"}, 32'(bus.done), 32'h0);
                check({name, "_hold_released"}, 32'(bus.cpu_hold), 32'h0);
            end
        end
        if (!seen) check({name, "_done_timeout"}, 32'h0, 32'h1);
        step();
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) step();
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'h0);
        check("rst_mem_we", 32'(bus.mem_we), 32'h0);
        check("rst_addr", 32'(bus.mem_addr), 32'h0);
        check("rst_hold", 32'(bus.cpu_hold), 32'h0);
        check("rst_error", 32'(bus.error), 32'h0);
        step();
        reset = 1'b0;
        step();

        // Two words, in_valid held high.
        exp_w.push_back('{8'h00, 16'h1234});
        exp_w.push_back('{8'h01, 16'hABCD});
        exp_d.push_back(1'b0);
        pulse_start();
        @(negedge clk);
        check("t1_hold_len_hi", 32'(bus.cpu_hold), 32'h1);
        check("t1_ready_len_hi", 32'(bus.in_ready), 32'h1);
        step();
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h12); send_byte(8'h34);
        send_byte(8'hAB); send_byte(8'hCD);
        bus.in_valid = 1'b0;
        wait_done("t1");
        check("t1_throughput", 32'(we_last - we_prev), 32'd3);
        check("t1_error", 32'(bus.error), 32'h0);

        // Zero length: error, no writes, sticky until next start.
        exp_d.push_back(1'b1);
        pulse_start();
        send_byte(8'h00); send_byte(8'h00);
        bus.in_valid = 1'b0;
        wait_done("t2");
        repeat (3) step();
        @(negedge clk);
        check("t2_error_sticky", 32'(bus.error), 32'h1);
        step();

        // Length 257 exceeds 256-word memory.
        exp_d.push_back(1'b1);
        pulse_start();
        @(negedge clk);
        check("t3_error_cleared", 32'(bus.error), 32'h0);
        step();
        send_byte(8'h01); send_byte(8'h01);
        bus.in_valid = 1'b0;
        wait_done("t3");
        check("t3_error", 32'(bus.error), 32'h1);

        // Stall mid-word, then single write one cycle after the last byte.
        exp_w.push_back('{8'h00, 16'h5AC3});
        exp_d.push_back(1'b0);
        pulse_start();
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h5A);
        bus.in_valid = 1'b0;
        repeat (3) step();
        send_byte(8'hC3);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("t4_latency_we", 32'(bus.mem_we), 32'h1);
        wait_done("t4");

        // Reset mid-load after one word and one byte.
        exp_w.push_back('{8'h00, 16'h1234});
        pulse_start();
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h12); send_byte(8'h34);
        send_byte(8'h56);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("t5_rst_we", 32'(bus.mem_we), 32'h0);
        check("t5_rst_hold", 32'(bus.cpu_hold), 32'h0);
        check("t5_rst_ready", 32'(bus.in_ready), 32'h0);
        check("t5_rst_done", 32'(bus.done), 32'h0);
        check("t5_rst_addr", 32'(bus.mem_addr), 32'h0);
        check("t5_rst_wdata", 32'(bus.mem_wdata), 32'h0);
        step();
        exp_w.push_back('{8'h00, 16'h1122});
        exp_d.push_back(1'b0);
        pulse_start();
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h11); send_byte(8'h22);
        bus.in_valid = 1'b0;
        wait_done("t5");

        // start during BYTE is ignored.
        exp_w.push_back('{8'h00, 16'hAABB});
        exp_w.push_back('{8'h01, 16'hCCDD});
        exp_d.push_back(1'b0);
        pulse_start();
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'hAA);
        bus.start = 1'b1;
        send_byte(8'hBB);
        bus.start = 1'b0;
        send_byte(8'hCC); send_byte(8'hDD);
        bus.in_valid = 1'b0;
        wait_done("t6");
        repeat (2) step();
        @(negedge clk);
        check("t6_still_idle", 32'(bus.cpu_hold), 32'h0);

        check("writes_drained", 32'(exp_w.size()), 32'h0);
        check("dones_drained", 32'(exp_d.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter WordSize, default 16: instruction word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter AddrWidth, default 8: instruction memory address width; capacity 2^AddrWidth words.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 start  input  1  request to begin a load; honoured only in IDLE.
REQ-006 in_valid  input  1  byte-stream data valid.
REQ-007 in_data  input  8  byte-stream payload.
REQ-008 in_ready  output  1  loader can accept a byte; a byte transfers on a cycle with in_valid=1 and in_ready=1.
REQ-009 mem_we  output  1  instruction-memory write strobe.
REQ-010 mem_addr  output  AddrWidth  instruction-memory write word address.
REQ-011 mem_wdata  output  WordSize  instruction-memory write data.
REQ-012 cpu_hold  output  1  holds PC/fetch while a load is in progress.
REQ-013 done  output  1  one-cycle pulse at end of a load.
REQ-014 error  output  1  sticky load-failure flag, cleared by the next accepted start or by reset.

Function
REQ-015 FSM states SHALL be IDLE, LEN_HI, LEN_LO, BYTE, WRITE, DONE.
REQ-016 IDLE: in_ready=0, cpu_hold=0; start=1 -> LEN_HI, word address cleared to 0, error cleared.
REQ-017 start SHALL be ignored in every state other than IDLE.
REQ-018 LEN_HI/LEN_LO: in_ready=1; each accepted byte SHALL form the high/low byte of a 16-bit word count N; no transfer -> stay.
REQ-019 After LEN_LO: N=0 or N>2^AddrWidth -> DONE with error set and no memory writes; otherwise -> BYTE with remaining=N.
REQ-020 BYTE: in_ready=1; accepted bytes SHALL be assembled MSB-first into the word register; after WordSize/8 bytes -> WRITE.
REQ-021 WRITE: in_ready=0, mem_we=1 for exactly one cycle with current mem_addr and assembled mem_wdata.
REQ-022 Leaving WRITE: mem_addr increments by 1, remaining decrements by 1; remaining reaches 0 -> DONE, else -> BYTE with the byte counter cleared.
REQ-023 Latency: the last byte of a word accepted in cycle t SHALL be written (mem_we=1) in cycle t+1.
REQ-024 Throughput: one word per WordSize/8+1 cycles when in_valid is held high.
REQ-025 in_valid deasserting mid-word SHALL stall without losing already accepted bytes.
REQ-026 DONE: done=1 for one cycle, in_ready=0, then -> IDLE.
REQ-027 cpu_hold SHALL be 1 in every state except IDLE.
REQ-028 mem_we SHALL be 0 in every state except WRITE; mem_addr SHALL not wrap within a load (guaranteed by REQ-019).
REQ-029 in_data SHALL be ignored whenever in_ready=0.

Reset
REQ-030 reset=1 SHALL force IDLE from any state, including mid-word and WRITE; reset has priority over start.
REQ-031 After reset: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, done=0, error=0, counters cleared; partially assembled word discarded; memory contents already written are untouched.

Verification
REQ-032 start; stream 00 02 12 34 AB CD, in_valid held high -> writes addr0=0x1234, addr1=0xABCD, one cycle each; done pulse; error=0; cpu_hold high from LEN_HI through DONE.
REQ-033 start; stream 00 00 -> no mem_we, done pulse, error=1 until next start.
REQ-034 start; stream 01 01 (N=257 > 256) -> no mem_we, done pulse, error=1.
REQ-035 start; N=1, bytes 5A, gap of 3 cycles with in_valid=0, then C3 -> single write addr0=0x5AC3 exactly one cycle after C3 is accepted.
REQ-036 start; N=2, after first word written and one byte of second accepted, reset=1 -> next cycle IDLE, mem_we=0, cpu_hold=0, no done; new start with N=1, bytes 11 22 -> write addr0=0x1122.
REQ-037 start pulsed during BYTE state -> ignored; address sequence and word count unaffected.
